// File: rtl/vram_arbiter.sv
// vram_arbiter: one-port character RAM shared between display scanout
// (strict priority on fetch edges), a buffered host write port and a
// full-screen clear sweep that use the remaining RAM cycles.
module vram_arbiter #(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 8,
  parameter int                FIFO_LOG2  = 2,
  parameter logic [DATA_W-1:0] CLEAR_CODE = 'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        CounterX,
  input  logic [8:0]        CounterY,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_req,
  output logic              clear_done,
  output logic              wr_addr_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] glyph_code,
  output logic              glyph_valid
);

  localparam int                DEPTH     = 1 << FIFO_LOG2;
  localparam int                FETCH_LAT = 2;   // address edge -> rdata load edge
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(2399);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  state_t                 state, state_nxt;
  wr_req_t                fifo_mem [DEPTH];
  wr_req_t                head;
  logic [FIFO_LOG2-1:0]   rd_ptr, wr_ptr;
  logic [FIFO_LOG2:0]     count;
  logic                   fifo_empty, fifo_full, push, pop;
  logic                   clr_wr, clear_last, head_ok;
  logic [ADDR_W-1:0]      sweep_ptr;
  logic                   fetch;
  logic [ADDR_W-1:0]      fetch_addr;
  logic [4:0]             row;
  logic [6:0]             col;
  logic [FETCH_LAT-1:0]   vld_pipe;
  logic [2:0]             hold_cnt;

  // Fetch edge decode and cell address row*80+col built from shifts.
  always_comb begin
    row        = CounterY[8:4];
    col        = CounterX[9:3];
    fetch      = (CounterX[2:0] == 3'd0) && (CounterX < 10'd640) && (CounterY < 9'd480);
    fetch_addr = (ADDR_W'(row) << 6) + (ADDR_W'(row) << 4) + ADDR_W'(col);
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (FIFO_LOG2+1)'(DEPTH));
  assign head       = fifo_mem[rd_ptr];
  assign head_ok    = (head.addr <= LAST_CELL);
  // Gated by rst so nothing can be accepted while the block is held in reset.
  assign wr_ready   = !rst && !fifo_full && (state == RUN);
  assign push       = wr_valid && wr_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next state plus per-edge choice of what uses the free RAM slot.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    clr_wr     = 1'b0;
    clear_last = 1'b0;
    case (state)
      RUN: begin
        pop = !fetch && !fifo_empty;
        if (clear_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        pop = !fetch && !fifo_empty;
        if (fifo_empty) state_nxt = CLEAR;
      end
      CLEAR: begin
        clr_wr = !fetch;
        if (!fetch && sweep_ptr == LAST_CELL) begin
          clear_last = 1'b1;
          state_nxt  = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // FIFO storage; contents need no reset, validity lives in count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: wr_addr, data: wr_data};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sweep pointer: parked at 0 outside CLEAR, advances per clear write.
  always_ff @(posedge clk) begin
    if (rst || state != CLEAR) sweep_ptr <= '0;
    else if (clr_wr)           sweep_ptr <= sweep_ptr + 1'b1;
  end

  // RAM port: fetch wins; otherwise host write, then clear write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      clear_done  <= 1'b0;
      wr_addr_err <= 1'b0;
    end else begin
      clear_done  <= clear_last;
      wr_addr_err <= pop && !head_ok;
      if (fetch) begin
        ram_addr <= fetch_addr;
        ram_we   <= 1'b0;
      end else if (pop && head_ok) begin
        ram_addr  <= head.addr;
        ram_wdata <= head.data;
        ram_we    <= 1'b1;
      end else if (clr_wr) begin
        ram_addr  <= sweep_ptr;
        ram_wdata <= CLEAR_CODE;
        ram_we    <= 1'b1;
      end else begin
        ram_we <= 1'b0;
      end
    end
  end

  // Scanout: load rdata two edges after a fetch, hold valid for 8 edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe    <= '0;
      hold_cnt    <= '0;
      glyph_code  <= '0;
      glyph_valid <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[FETCH_LAT-2:0], fetch};
      if (vld_pipe[FETCH_LAT-1]) begin
        glyph_code  <= ram_rdata;
        glyph_valid <= 1'b1;
        hold_cnt    <= 3'd7;
      end else if (hold_cnt != 3'd0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end else begin
        glyph_valid <= 1'b0;
      end
    end
  end

endmodule
